// File: rtl/es_ctrl_pkg.sv
// Shared opcode, strobe encodings and controller states for the execution-stack controller.
// ES_CTRL_OVF_TRAP_EN adds the TRAP state used by the optional overflow trap.
package es_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_DUP   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;

  localparam logic [1:0] ESOP_PUSH = 2'b00;
  localparam logic [1:0] ESOP_POP  = 2'b01;
  localparam logic [1:0] ESOP_DUP  = 2'b10;
  localparam logic [1:0] ESOP_NONE = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_POP,
    ST_PUSH,
    ST_DUP
`ifdef ES_CTRL_OVF_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  // Two-operand ALU ops consume two stack entries; ADDI consumes one.
  function automatic logic is_binary_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_ovf_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

  function automatic logic [1:0] alu_op_of(input logic [3:0] op);
    return (op == OP_ADDI) ? ALU_ADD : op[1:0];
  endfunction

endpackage

// File: rtl/es_ctrl_fsm_if.sv
// Instruction handshake plus execution-stack control strobes between fetch, controller and subsystem.
interface es_ctrl_fsm_if #(
  parameter int DEPTH_W = 5
);
  logic               instr_valid;
  logic               instr_ready;
  logic [15:0]        instr;
  logic               overflow;
  logic [15:0]        IRw;
  logic               popAmt;
  logic               ESAct;
  logic [1:0]         ESop;
  logic [1:0]         ALUOp;
  logic               ALUSrcB;
  logic               pushSel;
  logic               done;
  logic               err;
  logic               trap;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output instr_valid, instr, overflow,
    input  instr_ready, IRw, popAmt, ESAct, ESop, ALUOp, ALUSrcB, pushSel,
           done, err, trap, depth
  );

  modport slave (
    input  instr_valid, instr, overflow,
    output instr_ready, IRw, popAmt, ESAct, ESop, ALUOp, ALUSrcB, pushSel,
           done, err, trap, depth
  );
endinterface

// File: rtl/es_depth_tracker.sv
// Stack occupancy counter plus the admissibility check applied to the latched instruction.
module es_depth_tracker
  import es_ctrl_pkg::*;
#(
  parameter  int STACK_DEPTH = 16,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic [1:0]         dup_idx,
  input  logic               inc,
  input  logic               dec,
  input  logic               dec_two,
  output logic [DEPTH_W-1:0] depth,
  output logic               ok
);

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] depth_reg;
  logic [DEPTH_W-1:0] depth_next;
  logic               has_room;
  logic               has_one;
  logic               has_two;

  always_ff @(posedge clk) begin
    if (reset) depth_reg <= '0;
    else       depth_reg <= depth_next;
  end

  always_comb begin
    depth_next = depth_reg;
    if (inc)
      depth_next = depth_reg + DEPTH_W'(1);
    else if (dec)
      depth_next = depth_reg - (dec_two ? DEPTH_W'(2) : DEPTH_W'(1));
  end

  assign has_room = (depth_reg < FULL);
  assign has_one  = (depth_reg >= DEPTH_W'(1));
  assign has_two  = (depth_reg >= DEPTH_W'(2));

  // Illegal opcodes fall through to ok=0 so the controller rejects them like a depth fault.
  always_comb begin
    ok = 1'b0;
    case (opcode)
      OP_NOP:                         ok = 1'b1;
      OP_PUSHI:                       ok = has_room;
      OP_POP, OP_ADDI:                ok = has_one;
      OP_DUP:                         ok = has_room && (depth_reg > DEPTH_W'(dup_idx));
      OP_ADD, OP_SUB, OP_AND, OP_OR:  ok = has_two;
      default:                        ok = 1'b0;
    endcase
  end

  assign depth = depth_reg;

endmodule

// File: rtl/es_ctrl_fsm.sv
// Multicycle controller sequencing the execution stack one instruction at a time.
// Define ES_CTRL_OVF_TRAP_EN to halt in a sticky TRAP state on ALU overflow.
module es_ctrl_fsm
  import es_ctrl_pkg::*;
#(
  parameter  int STACK_DEPTH = 16,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  es_ctrl_fsm_if.slave bus
);

  state_t             state_reg;
  state_t             state_next;
  logic [15:0]        ir_reg;
  logic [3:0]         opcode;
  logic               ok;
  logic               inc;
  logic               dec;
  logic               dec_two;
  logic [DEPTH_W-1:0] depth;

  logic               ready;
  logic               es_act;
  logic [1:0]         es_op;
  logic [1:0]         alu_op;
  logic               alu_src_b;
  logic               push_sel;
  logic               pop_amt;
  logic               done;
  logic               err;
  logic               accept;

  assign opcode = ir_reg[15:12];
  assign accept = (state_reg == ST_IDLE) && !reset && bus.instr_valid;

  es_depth_tracker #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_depth (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .dup_idx (ir_reg[1:0]),
    .inc     (inc),
    .dec     (dec),
    .dec_two (dec_two),
    .depth   (depth),
    .ok      (ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) ir_reg <= bus.instr;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    es_act     = 1'b0;
    es_op      = ESOP_NONE;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    push_sel   = 1'b0;
    pop_amt    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;
    dec_two    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_next = ST_DECODE;
      end

      // Also the one cycle the A/B registers need to reload after the last stack write.
      ST_DECODE: begin
        if (!ok) begin
          err        = 1'b1;
          state_next = ST_IDLE;
        end else begin
          case (opcode)
            OP_NOP: begin
              done       = 1'b1;
              state_next = ST_IDLE;
            end
            OP_PUSHI: state_next = ST_PUSH;
            OP_POP:   state_next = ST_POP;
            OP_DUP:   state_next = ST_DUP;
            default:  state_next = ST_EXEC;
          endcase
        end
      end

      ST_EXEC: begin
        alu_op     = alu_op_of(opcode);
        alu_src_b  = (opcode == OP_ADDI);
        state_next = ST_POP;
`ifdef ES_CTRL_OVF_TRAP_EN
        if (is_ovf_op(opcode) && bus.overflow) state_next = ST_TRAP;
`endif
      end

      ST_POP: begin
        es_act  = 1'b1;
        es_op   = ESOP_POP;
        pop_amt = is_binary_alu(opcode);
        dec     = 1'b1;
        dec_two = pop_amt;
        if (opcode == OP_POP) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_PUSH;
        end
      end

      ST_PUSH: begin
        es_act     = 1'b1;
        es_op      = ESOP_PUSH;
        push_sel   = (opcode != OP_PUSHI);
        inc        = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      ST_DUP: begin
        es_act     = 1'b1;
        es_op      = ESOP_DUP;
        inc        = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end

`ifdef ES_CTRL_OVF_TRAP_EN
      ST_TRAP: state_next = ST_TRAP;
`endif

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.instr_ready = ready && !reset;
  assign bus.IRw         = ir_reg;
  assign bus.ESAct       = es_act;
  assign bus.ESop        = es_op;
  assign bus.ALUOp       = alu_op;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.pushSel     = push_sel;
  assign bus.popAmt      = pop_amt;
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.depth       = depth;

`ifdef ES_CTRL_OVF_TRAP_EN
  assign bus.trap = (state_reg == ST_TRAP);
`else
  logic unused_overflow;
  assign unused_overflow = bus.overflow;
  assign bus.trap        = 1'b0;
`endif

endmodule

// File: doc/es_ctrl_fsm.md
# es_ctrl_fsm

Multicycle control FSM that sequences the execution-stack subsystem (stack, A/B/ALUOut registers, sign extender, ALU) one instruction at a time. It accepts a 16-bit instruction over a valid/ready handshake, latches it, and drives the subsystem control strobes (popAmt, ESAct, ESop, ALUOp, ALUSrcB, push-source select). It also tracks stack occupancy to reject underflow/overflow before any stack side effect occurs. It sits between instruction fetch and the ES subsystem.

## Interface
- STACK_DEPTH, 16, number of entries in the execution stack
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  fetch offers instr
- instr_ready  out  1  controller accepts instr this cycle
- instr  in  16  instruction; opcode instr[15:12], imm8 instr[11:4], dup index instr[1:0]
- overflow  in  1  ALU overflow from the subsystem
- IRw  out  16  latched instruction to the subsystem
- popAmt  out  1  0 = pop 1, 1 = pop 2
- ESAct  out  1  stack operation enable
- ESop  out  2  00 push, 01 pop, 10 dup, 11 none
- ALUOp  out  2  00 add, 01 sub, 10 and, 11 or
- ALUSrcB  out  1  0 = B register, 1 = sign-extended imm
- pushSel  out  1  PushVal source: 0 = SEw, 1 = ALUOutWire
- done  out  1  one-cycle pulse, instruction retired
- err  out  1  one-cycle pulse, instruction rejected
- trap  out  1  sticky overflow trap (see Configuration)
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy

## Operation
- Opcodes: 0 NOP, 1 PUSHI, 2 POP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 ADDI. 9–15 are illegal.
- For opcodes 4–7, ALUOp = opcode[1:0]. ADDI uses ALUOp 00 with ALUSrcB=1.
- States: IDLE, DECODE, EXEC, POP, PUSH, DUP, TRAP.
- IDLE: instr_ready=1. On instr_valid, latch IRw and go to DECODE.
- DECODE: checks legality and depth.
  - Requirements: POP/ADDI need depth≥1. ADD–OR need depth≥2. DUP needs depth>instr[1:0] and depth<STACK_DEPTH. PUSHI needs depth<STACK_DEPTH.
  - On failure or illegal opcode: err pulse, go to IDLE, no ESAct.
  - NOP: done pulse, go to IDLE.
  - PUSHI → PUSH. POP → POP. DUP → DUP. ALU ops → EXEC.
- EXEC: drive ALUOp/ALUSrcB; ALUOut latches at the end of the cycle. Next state is POP.
- POP: ESAct=1, ESop=01.
  - popAmt=1 for ADD–OR, 0 for ADDI/POP.
  - POP opcode: done pulse, go to IDLE. Otherwise go to PUSH.
- PUSH: ESAct=1, ESop=00, pushSel=0 for PUSHI, 1 for ALU ops. done pulse, go to IDLE.
- DUP: ESAct=1, ESop=10, done pulse, go to IDLE.
- Depth updates at the edge ending POP (−1 or −2), PUSH (+1) and DUP (+1). Never wraps; the DECODE checks guarantee the range 0..STACK_DEPTH.
- Outputs are Moore, decoded from state and IRw. Idle defaults: ESAct=0, ESop=11, ALUOp=00, ALUSrcB=0, pushSel=0.
- ALU results wrap mod 2^16.

## Timing
- Reset: state IDLE, IRw=0, depth=0, trap=0. All strobes at idle defaults; done=err=0. instr_ready=0 while reset is high.
- Reset mid-instruction aborts at the next edge with no further stack strobes. Depth returns to 0, so the subsystem must be reset together with the controller.
- Latency, counted from the acceptance edge to the done pulse cycle:
  - NOP: 1 cycle.
  - PUSHI, POP, DUP: 2 cycles.
  - ADD–OR, ADDI: 4 cycles (DECODE, EXEC, POP, PUSH).
- DECODE gives the A/B registers one cycle to reload after the previous instruction's stack write.
- Back-to-back: instr_ready returns in the cycle after done/err. Throughput is therefore one instruction per latency+1 cycles.
- instr is ignored whenever instr_ready=0.

## Configuration
- ES_CTRL_OVF_TRAP_EN defined:
  - overflow is sampled in EXEC for ADD, SUB and ADDI.
  - If overflow=1, go to TRAP: no POP/PUSH, no done, trap=1, instr_ready=0.
  - TRAP is left only by reset.
- ES_CTRL_OVF_TRAP_EN undefined: overflow is ignored, trap is tied to 0, and the TRAP state is absent.

## Structure
- Shared package es_ctrl_pkg: opcode constants, ESop and ALUOp encodings, state enumeration.
- One sub-module, es_depth_tracker: the occupancy counter and the DECODE admissibility checks (inputs: opcode, dup index, inc/dec strobes; outputs: depth, ok).

## Test plan
- Reset, then PUSHI imm=0x05 and PUSHI imm=0xFE → PUSH cycles with pushSel=0. depth 1 then 2. done twice, each 2 cycles after acceptance.
- With stack [5, −2], ADD → EXEC ALUOp=00, POP popAmt=1, PUSH pushSel=1. depth 2→1. done 4 cycles after acceptance.
- Empty stack, ADD → err in DECODE, no ESAct ever asserted, depth stays 0, instr_ready=1 on the next cycle.
- Fill to 16 entries, then PUSHI → err. DUP index 3 at depth 3 → err. DUP index 2 at depth 3 → ESop=10, depth 4.
- Opcode 0xF → err. NOP → done 1 cycle after acceptance with no strobes.
- With ES_CTRL_OVF_TRAP_EN, ADD of 0x7FFF+1 with overflow=1 in EXEC → trap=1, no POP/PUSH, instr_ready held 0 until reset clears everything.
